// File: rtl/key_conditioner.sv
// key_conditioner: synchronise, debounce and strobe-encode active-low push-buttons
// Ports:
//    CLOCK_50    in   system clock, rising edge
//    reset       in   asynchronous active-high reset, clears all state
//    KEY_raw     in   raw buttons, active-low, asynchronous to CLOCK_50
//    key_level   out  debounced level, 1 = pressed
//    key_press   out  one-cycle strobe on accepted press
//    key_release out  one-cycle strobe on accepted release
//    key_repeat  out  one-cycle auto-repeat strobe while held (HOLD_CYCLES=0 disables)
module key_conditioner #(
   parameter int N_KEYS        = 4,
   parameter int DEB_CYCLES    = 1000,
   parameter int HOLD_CYCLES   = 0,
   parameter int REPEAT_CYCLES = 250
) (
   input  logic              CLOCK_50,
   input  logic              reset,
   input  logic [N_KEYS-1:0] KEY_raw,
   output logic [N_KEYS-1:0] key_level,
   output logic [N_KEYS-1:0] key_press,
   output logic [N_KEYS-1:0] key_release,
   output logic [N_KEYS-1:0] key_repeat
);
   localparam int DW   = $clog2(DEB_CYCLES + 1);
   localparam int RMAX = HOLD_CYCLES > REPEAT_CYCLES ? HOLD_CYCLES : REPEAT_CYCLES;
   localparam int RW   = $clog2(RMAX + 1);
   localparam logic [1:0] IDLE         = 2'd0;
   localparam logic [1:0] PRESS_WAIT   = 2'd1;
   localparam logic [1:0] PRESSED      = 2'd2;
   localparam logic [1:0] RELEASE_WAIT = 2'd3;
   localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
   localparam logic [RW-1:0] HOLD_LAST = RW'(HOLD_CYCLES - 1);
   localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_CYCLES - 1);
   for (genvar i = 0; i < N_KEYS; i++) begin : g_key
      logic [1:0]    r_sync;
      logic [1:0]    r_state;
      logic [DW-1:0] r_deb;
      logic [RW-1:0] r_rep;
      logic          r_first;
      logic          r_level, r_press, r_release, r_repeat;
      logic          w_s;
      logic [RW-1:0] w_rep_last;
      assign w_s        = r_sync[1];
      // r_first selects the initial hold delay until the first repeat has fired
      assign w_rep_last = r_first ? HOLD_LAST : REP_LAST;
      always_ff @(posedge CLOCK_50 or posedge reset) begin
         if (reset) begin
            r_sync    <= '0;
            r_state   <= IDLE;
            r_deb     <= '0;
            r_rep     <= '0;
            r_first   <= 1'b0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_repeat  <= 1'b0;
         end else begin
            r_sync    <= {r_sync[0], ~KEY_raw[i]};
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_repeat  <= 1'b0;
            case (r_state)
               IDLE: if (w_s) begin
                  r_state <= PRESS_WAIT;
                  r_deb   <= '0;
               end
               PRESS_WAIT: if (!w_s) r_state <= IDLE;
               else if (r_deb == DEB_LAST) begin
                  r_state <= PRESSED;
                  r_level <= 1'b1;
                  r_press <= 1'b1;
                  r_rep   <= '0;
                  r_first <= 1'b1;
               end else r_deb <= r_deb + 1'b1;
               PRESSED: if (!w_s) begin
                  r_state <= RELEASE_WAIT;
                  r_deb   <= '0;
               end else if (HOLD_CYCLES != 0) begin
                  // counter reloads at each strobe so it never exceeds its limit
                  if (r_rep == w_rep_last) begin
                     r_repeat <= 1'b1;
                     r_rep    <= '0;
                     r_first  <= 1'b0;
                  end else r_rep <= r_rep + 1'b1;
               end
               default: if (w_s) r_state <= PRESSED;
               else if (r_deb == DEB_LAST) begin
                  r_state   <= IDLE;
                  r_level   <= 1'b0;
                  r_release <= 1'b1;
               end else r_deb <= r_deb + 1'b1;
            endcase
         end
      end
      assign key_level[i]   = r_level;
      assign key_press[i]   = r_press;
      assign key_release[i] = r_release;
      assign key_repeat[i]  = r_repeat;
   end
endmodule

// File: tb/tb_key_conditioner.sv
// tb_key_conditioner: scoreboard bench for key_conditioner with a run-length reference model
module tb_key_conditioner;
   localparam int DEB  = 4;
   localparam int HOLD = 10;
   localparam int REP  = 5;
   typedef struct packed {
      logic [3:0] lvl;
      logic [3:0] prs;
      logic [3:0] rel;
      logic [3:0] rpt;
   } exp_t;
   logic       CLOCK_50 = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] KEY_raw = 4'hF;
   logic [3:0] key_level, key_press, key_release, key_repeat;
   int         errors = 0;
   int         checks = 0;
   exp_t       q[$];
   key_conditioner #(.N_KEYS(4), .DEB_CYCLES(DEB), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)) dut (
      .CLOCK_50(CLOCK_50), .reset(reset), .KEY_raw(KEY_raw),
      .key_level(key_level), .key_press(key_press),
      .key_release(key_release), .key_repeat(key_repeat)
   );
   always #5 CLOCK_50 = ~CLOCK_50;
   task automatic chk(input string name, input logic [3:0] got, input logic [3:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
      end
   endtask
   task automatic wait_edges(input int n);
      repeat (n) @(posedge CLOCK_50);
      #1;
   endtask
   task automatic set_raw(input logic [3:0] v);
      @(negedge CLOCK_50);
      #1;
      KEY_raw = v;
   endtask
   // Reference model: a key toggles once the synchronised input has disagreed with
   // the accepted level for DEB+1 consecutive samples; repeats are a function of the
   // number of held samples since the press.
   initial begin : model
      logic [3:0] s1, s2, lvl, s;
      int run[4], held[4];
      exp_t e;
      s1 = '0; s2 = '0; lvl = '0;
      for (int k = 0; k < 4; k++) begin run[k] = 0; held[k] = 0; end
      forever begin
         @(posedge CLOCK_50);
         e = '0;
         if (reset) begin
            s1 = '0; s2 = '0; lvl = '0;
            for (int k = 0; k < 4; k++) begin run[k] = 0; held[k] = 0; end
         end else begin
            s = s2; s2 = s1; s1 = ~KEY_raw;
            for (int k = 0; k < 4; k++) begin
               if (s[k] != lvl[k]) begin
                  run[k]++;
                  if (run[k] == DEB + 1) begin
                     lvl[k] = s[k];
                     run[k] = 0;
                     if (s[k]) begin e.prs[k] = 1'b1; held[k] = 0; end
                     else e.rel[k] = 1'b1;
                  end
               end else begin
                  if (lvl[k] && run[k] == 0) begin
                     held[k]++;
                     if (HOLD > 0 && held[k] >= HOLD && (held[k] - HOLD) % REP == 0) e.rpt[k] = 1'b1;
                  end
                  run[k] = 0;
               end
            end
         end
         e.lvl = lvl;
         q.push_back(e);
      end
   end
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge CLOCK_50);
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("sb_level", key_level, e.lvl);
            chk("sb_press", key_press, e.prs);
            chk("sb_release", key_release, e.rel);
            chk("sb_repeat", key_repeat, e.rpt);
         end
      end
   end
   initial begin : stim
      int tmr[4];
      logic [3:0] r;
      wait_edges(3);
      chk("rst_level", key_level, 4'b0000);
      chk("rst_press", key_press, 4'b0000);
      chk("rst_release", key_release, 4'b0000);
      chk("rst_repeat", key_repeat, 4'b0000);
      @(negedge CLOCK_50); #1; reset = 1'b0;
      wait_edges(3);
      // press latency, then repeat cadence while held
      set_raw(4'b1101);
      wait_edges(7);
      chk("t1_level", key_level, 4'b0010);
      chk("t1_press", key_press, 4'b0010);
      for (int k = 1; k <= 20; k++) begin
         wait_edges(1);
         chk("t1_press_clear", key_press, 4'b0000);
         chk("t3_repeat", key_repeat, (k == 10 || k == 15 || k == 20) ? 4'b0010 : 4'b0000);
      end
      // release with a bounce
      set_raw(4'b1111);
      repeat (2) begin wait_edges(1); chk("t4_hold", key_level, 4'b0010); end
      set_raw(4'b1101);
      repeat (3) begin wait_edges(1); chk("t4_hold", key_level, 4'b0010); end
      set_raw(4'b1111);
      for (int j = 1; j <= 7; j++) begin
         wait_edges(1);
         chk("t4_release", key_release, j == 7 ? 4'b0010 : 4'b0000);
         chk("t4_level", key_level, j == 7 ? 4'b0000 : 4'b0010);
      end
      wait_edges(20);
      // short glitch rejected, DEB+1 glitch accepted
      set_raw(4'b1011);
      wait_edges(3);
      set_raw(4'b1111);
      repeat (12) begin
         wait_edges(1);
         chk("t2_no_press", key_press, 4'b0000);
         chk("t2_no_level", key_level, 4'b0000);
      end
      set_raw(4'b1011);
      wait_edges(5);
      set_raw(4'b1111);
      wait_edges(2);
      chk("t2_glitch_press", key_press, 4'b0100);
      wait_edges(20);
      // simultaneous presses
      set_raw(4'b0110);
      wait_edges(7);
      chk("t5_press", key_press, 4'b1001);
      chk("t5_level", key_level, 4'b1001);
      set_raw(4'b1111);
      wait_edges(20);
      // reset while held
      set_raw(4'b1101);
      wait_edges(9);
      chk("t6_pre_level", key_level, 4'b0010);
      @(negedge CLOCK_50); #1; reset = 1'b1;
      #1;
      chk("t6_async_level", key_level, 4'b0000);
      chk("t6_async_press", key_press, 4'b0000);
      chk("t6_async_release", key_release, 4'b0000);
      chk("t6_async_repeat", key_repeat, 4'b0000);
      wait_edges(2);
      @(negedge CLOCK_50); #1; reset = 1'b0;
      for (int j = 1; j <= 7; j++) begin
         wait_edges(1);
         chk("t6_repress", key_press, j == 7 ? 4'b0010 : 4'b0000);
         chk("t6_no_release", key_release, 4'b0000);
      end
      set_raw(4'b1111);
      wait_edges(20);
      // randomized bouncing keys with rare reset pulses
      r = 4'hF;
      for (int k = 0; k < 4; k++) tmr[k] = $urandom_range(1, 24);
      for (int c = 0; c < 800; c++) begin
         for (int k = 0; k < 4; k++) begin
            if (tmr[k] == 0) begin
               r[k] = ~r[k];
               tmr[k] = $urandom_range(1, 24);
            end else tmr[k]--;
         end
         @(negedge CLOCK_50); #1;
         KEY_raw = r;
         reset = ($urandom_range(0, 299) == 0);
      end
      @(negedge CLOCK_50); #1; reset = 1'b0; KEY_raw = 4'hF;
      wait_edges(30);
      @(negedge CLOCK_50); #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
